// File: rtl/jala_mem_pkg.sv
// Shared types and default sizing for the wait-state memory responder.
package jala_mem_pkg;

    localparam int DEF_ADDR_W      = 16;
    localparam int DEF_DATA_W      = 16;
    localparam int DEF_DEPTH       = 256;
    localparam int DEF_WAIT_STATES = 2;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    typedef enum logic {
        OP_RD,
        OP_WR
    } op_t;

    // A simultaneous read and write resolves to a read.
    function automatic op_t decode_op(input logic rd, input logic wr);
        return (wr && !rd) ? OP_WR : OP_RD;
    endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Requester/responder handshake bundle for mem_responder.
interface mem_responder_if
    import jala_mem_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);
    logic              MemRead;
    logic              MemWrite;
    logic [ADDR_W-1:0] MemAddr;
    logic [DATA_W-1:0] MemDataIn;
    logic [DATA_W-1:0] MemDataOut;
    logic              MemReady;
    logic              MemErr;

    modport master (
        output MemRead, MemWrite, MemAddr, MemDataIn,
        input  MemDataOut, MemReady, MemErr
    );

    modport slave (
        input  MemRead, MemWrite, MemAddr, MemDataIn,
        output MemDataOut, MemReady, MemErr
    );
endinterface

// File: rtl/mem_resp_array.sv
// Word storage: synchronous write, combinational read, contents never reset.
module mem_resp_array #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 256,
    parameter int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];
endmodule

// File: rtl/mem_responder.sv
// Memory responder with WAIT_STATES programmable latency and one-cycle MemReady.
// Optional range/conflict error reporting is enabled by MEM_RESPONDER_ERR_EN.
module mem_responder
    import jala_mem_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int DEPTH       = DEF_DEPTH,
    parameter int WAIT_STATES = DEF_WAIT_STATES
) (
    input  logic            CLK,
    input  logic            RST_N,
    mem_responder_if.slave  bus
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_t            state_reg, state_next;
    logic [3:0]        count_reg, count_next;
    op_t               op_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [DATA_W-1:0] data_reg;
    logic              err_reg;

    logic              ready_reg;
    logic              err_out_reg;
    logic [DATA_W-1:0] dout_reg;

    logic              req;
    logic              sample;
    logic              err_in;
    op_t               op_eff;
    logic [ADDR_W-1:0] addr_eff;
    logic [DATA_W-1:0] data_eff;
    logic              err_eff;
    logic [IDX_W-1:0]  idx_eff;
    logic              enter_resp;
    logic              we;
    logic [DATA_W-1:0] rdata;

    assign req    = bus.MemRead | bus.MemWrite;
    assign sample = (state_reg == IDLE) && req;

`ifdef MEM_RESPONDER_ERR_EN
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
    assign err_in = ({1'b0, bus.MemAddr} >= DEPTH_L) || (bus.MemRead && bus.MemWrite);
`else
    assign err_in = 1'b0;
`endif

    // On the sampling edge the live request is used directly so WAIT_STATES=0 works.
    assign op_eff   = sample ? decode_op(bus.MemRead, bus.MemWrite) : op_reg;
    assign addr_eff = sample ? bus.MemAddr   : addr_reg;
    assign data_eff = sample ? bus.MemDataIn : data_reg;
    assign err_eff  = sample ? err_in        : err_reg;
    assign idx_eff  = IDX_W'(addr_eff % DEPTH);

    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        case (state_reg)
            IDLE: begin
                if (req) begin
                    if (WAIT_STATES == 0) begin
                        state_next = RESP;
                    end else begin
                        state_next = WAIT;
                        count_next = 4'(WAIT_STATES - 1);
                    end
                end
            end
            WAIT: begin
                if (!req) begin
                    state_next = IDLE;
                    count_next = '0;
                end else if (count_reg == 4'd0) begin
                    state_next = RESP;
                end else begin
                    count_next = count_reg - 4'd1;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign enter_resp = (state_next == RESP);
    // Gating with RST_N keeps a held request from committing while reset is asserted.
    assign we = enter_resp && (op_eff == OP_WR) && !err_eff && RST_N;

    mem_resp_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_array (
        .clk   (CLK),
        .we    (we),
        .addr  (idx_eff),
        .wdata (data_eff),
        .rdata (rdata)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_reg   <= IDLE;
            count_reg   <= '0;
            op_reg      <= OP_RD;
            addr_reg    <= '0;
            data_reg    <= '0;
            err_reg     <= 1'b0;
            ready_reg   <= 1'b0;
            err_out_reg <= 1'b0;
            dout_reg    <= '0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            if (sample) begin
                op_reg   <= op_eff;
                addr_reg <= bus.MemAddr;
                data_reg <= bus.MemDataIn;
                err_reg  <= err_in;
            end
            ready_reg   <= enter_resp;
            err_out_reg <= enter_resp && err_eff;
            dout_reg    <= (enter_resp && (op_eff == OP_RD) && !err_eff) ? rdata : '0;
        end
    end

    assign bus.MemReady   = ready_reg;
    assign bus.MemErr     = err_out_reg;
    assign bus.MemDataOut = dout_reg;
endmodule

// File: tb/tb_mem_responder.sv
// Directed self-checking bench for mem_responder (WAIT_STATES=2 and WAIT_STATES=0 instances).
module tb_mem_responder;
    import jala_mem_pkg::*;

    logic CLK = 1'b0;
    logic RST_N;
    int   checks   = 0;
    int   failures = 0;

    always #5 CLK = ~CLK;

    mem_responder_if #(.ADDR_W(16), .DATA_W(16)) bus  ();
    mem_responder_if #(.ADDR_W(16), .DATA_W(16)) bus0 ();

    mem_responder #(.ADDR_W(16), .DATA_W(16), .DEPTH(256), .WAIT_STATES(2)) u_dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus.slave)
    );

    mem_responder #(.ADDR_W(16), .DATA_W(16), .DEPTH(256), .WAIT_STATES(0)) u_dut0 (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus0.slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Full transaction on the WAIT_STATES=2 instance; address/data are scrambled after sampling.
    task automatic txn(input string tag, input logic rd, input logic wr,
                       input logic [15:0] addr, input logic [15:0] data,
                       input logic [15:0] exp_data, input logic exp_err);
        bus.MemRead   = rd;
        bus.MemWrite  = wr;
        bus.MemAddr   = addr;
        bus.MemDataIn = data;
        for (int k = 0; k < 2; k++) begin
            tick();
            chk({tag, "_wait_rdy"}, 32'(bus.MemReady), 32'd0);
            chk({tag, "_wait_dout"}, 32'(bus.MemDataOut), 32'd0);
            if (k == 0) begin
                bus.MemAddr   = ~addr;
                bus.MemDataIn = ~data;
            end
        end
        tick();
        chk({tag, "_resp_rdy"}, 32'(bus.MemReady), 32'd1);
        chk({tag, "_resp_dout"}, 32'(bus.MemDataOut), 32'(exp_data));
        chk({tag, "_resp_err"}, 32'(bus.MemErr), 32'(exp_err));
        $display("txn %s rd=%0b wr=%0b addr=%h dout=%h err=%0b", tag, rd, wr, addr,
                 bus.MemDataOut, bus.MemErr);
        bus.MemRead  = 1'b0;
        bus.MemWrite = 1'b0;
        tick();
        chk({tag, "_after_rdy"}, 32'(bus.MemReady), 32'd0);
        chk({tag, "_after_dout"}, 32'(bus.MemDataOut), 32'd0);
    endtask

    initial begin
        bus.MemRead = 0;  bus.MemWrite = 0;  bus.MemAddr = '0;  bus.MemDataIn = '0;
        bus0.MemRead = 0; bus0.MemWrite = 0; bus0.MemAddr = '0; bus0.MemDataIn = '0;
        RST_N = 1'b1;
        #1 RST_N = 1'b0;
        #1;
        chk("reset_rdy", 32'(bus.MemReady), 32'd0);
        chk("reset_err", 32'(bus.MemErr), 32'd0);
        chk("reset_dout", 32'(bus.MemDataOut), 32'd0);
        chk("reset_state", 32'(u_dut.state_reg), 32'(IDLE));
        tick();
        tick();
        @(negedge CLK) RST_N = 1'b1;
        tick();
        chk("post_reset_rdy", 32'(bus.MemReady), 32'd0);

        txn("wr_beef", 1'b1 ^ 1'b1, 1'b1, 16'h0010, 16'hBEEF, 16'h0000, 1'b0);
        txn("rd_beef", 1'b1, 1'b0, 16'h0010, 16'h0000, 16'hBEEF, 1'b0);
        txn("wr_5555", 1'b0, 1'b1, 16'h0020, 16'h5555, 16'h0000, 1'b0);

        // Write aborted by reset while in WAIT
        bus.MemWrite = 1'b1; bus.MemAddr = 16'h0020; bus.MemDataIn = 16'h1234;
        tick();
        chk("rstab_wait_state", 32'(u_dut.state_reg), 32'(WAIT));
        #2 RST_N = 1'b0;
        #1;
        chk("rstab_state", 32'(u_dut.state_reg), 32'(IDLE));
        chk("rstab_rdy", 32'(bus.MemReady), 32'd0);
        bus.MemWrite = 1'b0;
        @(negedge CLK) RST_N = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("rstab_no_rdy", 32'(bus.MemReady), 32'd0);
        end
        $display("txn rstab write 0020 aborted by reset");
        txn("rd_after_abort", 1'b1, 1'b0, 16'h0020, 16'h0000, 16'h5555, 1'b0);

        // Read dropped one cycle after sampling
        bus.MemRead = 1'b1; bus.MemAddr = 16'h0030;
        tick();
        chk("drop_state_wait", 32'(u_dut.state_reg), 32'(WAIT));
        chk("drop_rdy0", 32'(bus.MemReady), 32'd0);
        bus.MemRead = 1'b0;
        tick();
        chk("drop_state_idle", 32'(u_dut.state_reg), 32'(IDLE));
        chk("drop_rdy1", 32'(bus.MemReady), 32'd0);
        tick();
        chk("drop_rdy2", 32'(bus.MemReady), 32'd0);
        $display("txn drop read 0030 aborted");

        txn("wr_0f0f", 1'b0, 1'b1, 16'h0000, 16'h0F0F, 16'h0000, 1'b0);
`ifdef MEM_RESPONDER_ERR_EN
        txn("rd_oob", 1'b1, 1'b0, 16'h0100, 16'h0000, 16'h0000, 1'b1);
        txn("rw_both", 1'b1, 1'b1, 16'h0010, 16'h9999, 16'h0000, 1'b1);
`else
        txn("rd_wrap", 1'b1, 1'b0, 16'h0100, 16'h0000, 16'h0F0F, 1'b0);
        txn("rw_both", 1'b1, 1'b1, 16'h0010, 16'h9999, 16'hBEEF, 1'b0);
`endif
        txn("rd_beef2", 1'b1, 1'b0, 16'h0010, 16'h0000, 16'hBEEF, 1'b0);

        // Zero wait states: write then continuously held read
        bus0.MemWrite = 1'b1; bus0.MemAddr = 16'h0005; bus0.MemDataIn = 16'hA5A5;
        tick();
        chk("ws0_wr_rdy", 32'(bus0.MemReady), 32'd1);
        chk("ws0_wr_err", 32'(bus0.MemErr), 32'd0);
        $display("txn ws0 write 0005 A5A5 rdy=%0b", bus0.MemReady);
        bus0.MemWrite = 1'b0; bus0.MemRead = 1'b1;
        tick();
        chk("ws0_gap0_rdy", 32'(bus0.MemReady), 32'd0);
        chk("ws0_gap0_dout", 32'(bus0.MemDataOut), 32'd0);
        for (int k = 0; k < 2; k++) begin
            tick();
            chk("ws0_rd_rdy", 32'(bus0.MemReady), 32'd1);
            chk("ws0_rd_dout", 32'(bus0.MemDataOut), 32'hA5A5);
            $display("txn ws0 read 0005 dout=%h", bus0.MemDataOut);
            if (k == 1) bus0.MemRead = 1'b0;
            tick();
            chk("ws0_gap_rdy", 32'(bus0.MemReady), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter ADDR_W, default 16, address width in bits.
REQ-002 Parameter DATA_W, default 16, data word width in bits.
REQ-003 Parameter DEPTH, default 256, number of implemented words.
REQ-004 Parameter WAIT_STATES, default 2, extra cycles before response; range 0..15.
REQ-005 CLK  input  1  single clock; all state changes on rising edge.
REQ-006 RST_N  input  1  reset, asynchronous assert, active-low.
REQ-007 MemRead  input  1  read request; held by requester until MemReady.
REQ-008 MemWrite  input  1  write request; held by requester until MemReady.
REQ-009 MemAddr  input  ADDR_W  word address; held stable with the request.
REQ-010 MemDataIn  input  DATA_W  write data; held stable with the request.
REQ-011 MemDataOut  output  DATA_W  read data; valid only while MemReady=1 for a read.
REQ-012 MemReady  output  1  one-cycle completion pulse.
REQ-013 MemErr  output  1  error flag; valid only while MemReady=1.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, WAIT, RESP.
REQ-015 In IDLE, the first edge with MemRead|MemWrite=1 SHALL latch op, address, and data, then go to WAIT; if WAIT_STATES=0, it SHALL go directly to RESP.
REQ-016 WAIT SHALL load counter=WAIT_STATES-1 on entry, decrement once per cycle, and go to RESP on the edge where counter=0.
REQ-017 MemReady SHALL be high for exactly the one cycle spent in RESP: WAIT_STATES+1 edges after the sampling edge.
REQ-018 RESP SHALL always return to IDLE on the next edge without sampling a request; minimum request-to-request spacing is WAIT_STATES+2 cycles.
REQ-019 A write SHALL commit to storage on the edge that enters RESP; a read SHALL present the latched-address word on MemDataOut during RESP.
REQ-020 If MemRead and MemWrite both drop during WAIT, the FSM SHALL abort to IDLE on the next edge: no write, no MemReady.
REQ-021 Outside RESP, MemDataOut SHALL be 0, and MemReady and MemErr SHALL be 0.
REQ-022 MemAddr and MemDataIn changes after the sampling edge SHALL be ignored; only the latched values are used.
REQ-023 Read-after-write to the same address in back-to-back transactions SHALL return the newly written data.

Reset
REQ-024 RST_N=0 SHALL immediately force state=IDLE, counter=0, MemReady=0, MemErr=0, and MemDataOut=0.
REQ-025 Reset during WAIT or RESP SHALL discard the pending transaction; a pending write SHALL NOT commit.
REQ-026 Storage contents SHALL NOT be reset.
REQ-027 After RST_N deasserts, the first sampling edge SHALL be the first rising edge with RST_N=1.

Configuration
REQ-028 With macro MEM_RESPONDER_ERR_EN defined, MemErr SHALL be 1 in RESP when MemAddr>=DEPTH or when MemRead and MemWrite are both 1 at sampling. In that case no write commits and MemDataOut=0.
REQ-029 Without MEM_RESPONDER_ERR_EN, MemErr SHALL be tied 0, the address SHALL wrap modulo DEPTH, and a simultaneous read and write SHALL be treated as a read.

Structure
REQ-030 Package jala_mem_pkg SHALL hold the state typedef (IDLE/WAIT/RESP), the default ADDR_W/DATA_W/DEPTH/WAIT_STATES constants, and the op-code typedef (OP_RD/OP_WR).
REQ-031 Storage SHALL be the sub-module mem_resp_array: synchronous write, combinational read, no reset.
REQ-032 The FSM, counter, request latches, and output registers SHALL live in mem_responder.

Verification
REQ-033 Reset, then write 0xBEEF to address 0x0010 with WAIT_STATES=2 -> MemReady pulses once, 3 edges after sampling; MemErr=0.
REQ-034 Read address 0x0010 immediately after REQ-033 -> MemDataOut=0xBEEF during the MemReady cycle, and 0x0000 in the cycles before and after.
REQ-035 Write request to 0x0020 with data 0x1234; RST_N pulsed low during WAIT; then read 0x0020 -> the prior contents are returned and MemReady never pulses for the aborted write.
REQ-036 Read request to 0x0030 dropped one cycle after sampling -> no MemReady; the FSM is in IDLE 1 edge later.
REQ-037 With MEM_RESPONDER_ERR_EN: read of 0x0100 (DEPTH=256) -> MemErr=1 and MemDataOut=0; without the macro, the same read returns the word at 0x0000.
REQ-038 With WAIT_STATES=0: a write followed by a read with MemRead held continuously -> MemReady on every second cycle, and the read returns the written data.
